// File: rtl/tt_kavinmalar_sub_pkg.sv
// Shared state encoding, pin indices and constants for the bit-serial subtractor tile.
package tt_kavinmalar_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Status indices carry a _BIT suffix so they do not clash with the DONE state.
  localparam int unsigned LOAD_A_BIT = 0;
  localparam int unsigned LOAD_B_BIT = 1;
  localparam int unsigned START_BIT  = 2;

  localparam int unsigned BUSY_BIT   = 3;
  localparam int unsigned DONE_BIT   = 4;
  localparam int unsigned BORROW_BIT = 5;

  localparam logic [7:0] UIO_OE_MASK = 8'h38;

endpackage

// File: rtl/serial_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module serial_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/tt_um_kavinmalar_serial_subtractor.sv
// Bit-serial 8-bit unsigned subtractor (A-B, LSB first) packaged as a Tiny Tapeout tile.
module tt_um_kavinmalar_serial_subtractor
  import tt_kavinmalar_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, r_reg, w_reg;
  logic [CW-1:0]    cnt;
  logic             bin, borrow;
  logic             d, bout;

  logic load_a, load_b, start, any_load;
  logic unused_ok;

  assign load_a    = uio_in[LOAD_A_BIT];
  assign load_b    = uio_in[LOAD_B_BIT];
  assign start     = uio_in[START_BIT];
  assign any_load  = load_a | load_b;
  assign unused_ok = &{1'b0, uio_in[7:3]};

  serial_sub_bit u_bit (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        // A load always wins over a simultaneous start.
        if (any_load)   state_next = IDLE;
        else if (start) state_next = RUN;
      end
      RUN:     if (cnt == LAST) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      w_reg  <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      borrow <= 1'b0;
    end else if (ena) begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (load_a) a_reg <= ui_in;
          if (load_b) b_reg <= ui_in;
          if (!any_load && start) begin
            cnt <= '0;
            bin <= 1'b0;
          end
        end
        RUN: begin
          w_reg <= {d, w_reg[WIDTH-1:1]};
          bin   <= bout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            r_reg  <= {d, w_reg[WIDTH-1:1]};
            borrow <= bout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    uio_out             = '0;
    uio_out[BUSY_BIT]   = (state == RUN);
    uio_out[DONE_BIT]   = (state == DONE);
    uio_out[BORROW_BIT] = borrow;
  end

  assign uo_out = r_reg;
  assign uio_oe = UIO_OE_MASK;

endmodule
